// File: rtl/video_timing_tx.sv
// Raster timing generator and RGB565 pixel transmitter fed by a valid/ready stream.
// Aligns to the stream's start-of-frame marker and flags underflow and frame misalignment.
module video_timing_tx #(
  parameter int H_DISP   = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_DISP   = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear_err,
  input  logic [15:0] pix_data,
  input  logic        pix_sof,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        vout_vs,
  output logic        vout_hs,
  output logic        vout_de,
  output logic [15:0] vout_data,
  output logic        underflow,
  output logic        sof_err
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_DISP);
  localparam logic [HW-1:0] H_SS   = HW'(H_DISP + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_DISP + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_ONE  = HW'(1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_DISP);
  localparam logic [VW-1:0] V_SS   = VW'(V_DISP + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_DISP + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_ONE  = VW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic          r_hs;
  logic          r_vs;
  logic          r_de;
  logic [15:0]   r_data;
  logic          r_underflow;
  logic          r_sof_err;

  logic w_wrap;
  logic w_active;
  logic w_hs;
  logic w_vs;
  logic w_frame_start;
  logic w_sof_bad;
  logic w_uf_set;
  logic w_serr_set;
  logic w_load;

  assign w_wrap        = (r_hcnt == H_LAST) && (r_vcnt == V_LAST);
  assign w_active      = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_hs          = (r_hcnt >= H_SS) && (r_hcnt < H_SE);
  assign w_vs          = (r_vcnt >= V_SS) && (r_vcnt < V_SE);
  assign w_frame_start = (r_hcnt == '0) && (r_vcnt == '0);
  // A SOF marker is only legal on the very first active slot of a frame.
  assign w_sof_bad     = pix_valid && (pix_sof != w_frame_start);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_ALIGN;
        else        w_state_nxt = S_IDLE;
      end
      S_ALIGN: begin
        if (w_wrap && !enable)                      w_state_nxt = S_IDLE;
        else if (w_wrap && pix_valid && pix_sof)    w_state_nxt = S_RUN;
        else                                        w_state_nxt = S_ALIGN;
      end
      S_RUN: begin
        if (w_wrap && !enable)                      w_state_nxt = S_IDLE;
        else if (w_active && w_sof_bad)             w_state_nxt = S_ALIGN;
        else                                        w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pix_ready  = 1'b0;
    w_uf_set   = 1'b0;
    w_serr_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        pix_ready = 1'b0;
      end
      S_ALIGN: begin
        // Drain everything up to the SOF word, which stays parked at the stream head.
        pix_ready = pix_valid && !pix_sof;
      end
      S_RUN: begin
        pix_ready  = w_active && !w_sof_bad;
        w_uf_set   = w_active && !pix_valid;
        w_serr_set = w_active && w_sof_bad;
      end
      default: begin
        pix_ready = 1'b0;
      end
    endcase
  end

  assign w_load = (r_state == S_RUN) && pix_valid && pix_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == H_LAST) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + V_ONE;
    end else begin
      r_hcnt <= r_hcnt + H_ONE;
    end
  end

  // Sync outputs use XNOR with the polarity so idle/reset always shows the inactive level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs        <= ~SYNC_POL;
      r_vs        <= ~SYNC_POL;
      r_de        <= 1'b0;
      r_data      <= 16'h0000;
      r_underflow <= 1'b0;
      r_sof_err   <= 1'b0;
    end else begin
      r_hs        <= ((r_state != S_IDLE) && w_hs) ~^ SYNC_POL;
      r_vs        <= ((r_state != S_IDLE) && w_vs) ~^ SYNC_POL;
      r_de        <= (r_state != S_IDLE) && w_active;
      r_data      <= w_load ? pix_data : 16'h0000;
      r_underflow <= w_uf_set | (r_underflow & ~clear_err);
      r_sof_err   <= w_serr_set | (r_sof_err & ~clear_err);
    end
  end

  assign vout_hs   = r_hs;
  assign vout_vs   = r_vs;
  assign vout_de   = r_de;
  assign vout_data = r_data;
  assign underflow = r_underflow;
  assign sof_err   = r_sof_err;

endmodule

// File: tb/tb_video_timing_tx.sv
// Bench for video_timing_tx on a 14x7 raster: a cycle model pushes expected outputs
// to a scoreboard as stimulus is driven; each scenario task drains and compares.
module tb_video_timing_tx;

  localparam int HD = 8, HF = 2, HS = 2, HB = 2;
  localparam int VD = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        clear_err = 1'b0;
  logic [15:0] pix_data = 16'h0000;
  logic        pix_sof = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        vout_vs;
  logic        vout_hs;
  logic        vout_de;
  logic [15:0] vout_data;
  logic        underflow;
  logic        sof_err;

  always #5 clk = ~clk;

  video_timing_tx #(
    .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear_err(clear_err),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .vout_vs(vout_vs), .vout_hs(vout_hs), .vout_de(vout_de), .vout_data(vout_data),
    .underflow(underflow), .sof_err(sof_err)
  );

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [15:0] data;
  } vout_t;

  typedef struct packed {
    logic        sof;
    logic [15:0] data;
  } word_t;

  vout_t exp_q[$];
  vout_t act_q[$];
  word_t src_q[$];
  int    n_assert = 0;
  int    n_fail = 0;
  int    pos = 0;      // expected raster position hcnt + vcnt*HT
  int    mode = 0;     // expected state: 0 idle, 1 align, 2 run
  int    gap_pos = -1; // raster position where the source withholds valid once

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    vout_t e;
    vout_t a;
    word_t w;
    logic  v;
    logic  acc;
    logic  act;
    int    h;
    int    ln;
    int    nmode;
    v = (src_q.size() > 0);
    if (mode == 2 && pos == gap_pos) begin
      v = 1'b0;
      gap_pos = -1;
    end
    w = v ? src_q[0] : '0;
    pix_valid = v;
    pix_sof   = w.sof;
    pix_data  = w.data;
    h   = pos % HT;
    ln  = pos / HT;
    act = (h < HD) && (ln < VD);
    e = '0;
    acc = 1'b0;
    nmode = mode;
    if (mode != 0) begin
      e.de = act;
      e.hs = (h >= HD + HF) && (h < HD + HF + HS);
      e.vs = (ln >= VD + VF) && (ln < VD + VF + VS);
    end
    if (mode == 0) begin
      if (enable) nmode = 1;
    end else if (mode == 1) begin
      acc = v && !w.sof;
      if (pos == FT - 1) nmode = !enable ? 0 : ((v && w.sof) ? 2 : 1);
    end else begin
      if (act && v && (w.sof == (pos == 0))) begin
        acc = 1'b1;
        e.data = w.data;
      end else if (act && v) begin
        nmode = 1;
      end
      if (pos == FT - 1 && !enable) nmode = 0;
    end
    exp_q.push_back(e);
    step();
    a.de = vout_de;
    a.hs = vout_hs;
    a.vs = vout_vs;
    a.data = vout_data;
    act_q.push_back(a);
    if (acc) w = src_q.pop_front();
    if (mode != 0) pos = (pos + 1) % FT;
    mode = nmode;
  endtask

  task automatic tick_until(input int p);
    for (int i = 0; i < FT && pos != p; i++) tick();
  endtask

  task automatic push_frame(input logic [15:0] base);
    word_t w;
    for (int k = 0; k < VD * HD; k++) begin
      w.sof  = (k == 0);
      w.data = base + 16'(k + 1);
      src_q.push_back(w);
    end
  endtask

  task automatic push_junk(input int n);
    word_t w;
    for (int k = 0; k < n; k++) begin
      w.sof  = 1'b0;
      w.data = 16'hBAD0 + 16'(k + 1);
      src_q.push_back(w);
    end
  endtask

  task automatic test_reset();
    vout_t e;
    vout_t a;
    #12;
    n_assert++;
    if ({vout_de, vout_hs, vout_vs, vout_data, underflow, sof_err, pix_ready} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_levels: got de=%b hs=%b vs=%b data=%h uf=%b serr=%b rdy=%b, expected all 0",
               vout_de, vout_hs, vout_vs, vout_data, underflow, sof_err, pix_ready);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_assert++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL idle: got de=%b hs=%b vs=%b data=%h, expected de=%b hs=%b vs=%b data=%h",
                 a.de, a.hs, a.vs, a.data, e.de, e.hs, e.vs, e.data);
      end
    end
  endtask

  task automatic test_blank_align();
    vout_t e;
    vout_t a;
    enable = 1'b1;
    tick();
    for (int i = 0; i < FT; i++) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_assert++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL align_blank: got de=%b hs=%b vs=%b data=%h, expected de=%b hs=%b vs=%b data=%h",
                 a.de, a.hs, a.vs, a.data, e.de, e.hs, e.vs, e.data);
      end
    end
    n_assert++;
    if ({sof_err, underflow} !== 2'b00) begin
      n_fail++;
      $display("FAIL align_flags: got sof_err=%b underflow=%b, expected 0 0", sof_err, underflow);
    end
  endtask

  task automatic test_stream();
    vout_t e;
    vout_t a;
    tick_until(90);
    push_frame(16'h0000);
    tick_until(0);
    tick_until(60);
    push_frame(16'h0100);
    tick_until(0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_assert++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL stream: got de=%b hs=%b vs=%b data=%h, expected de=%b hs=%b vs=%b data=%h",
                 a.de, a.hs, a.vs, a.data, e.de, e.hs, e.vs, e.data);
      end
    end
    n_assert++;
    if (underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_uf: got %b, expected 0", underflow);
    end
  endtask

  task automatic test_underflow();
    vout_t e;
    vout_t a;
    gap_pos = 2 * HT + 5;
    tick_until(2 * HT + 5);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_assert++;
    if (underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_set_wins: got %b, expected 1", underflow);
    end
    tick_until(80);
    n_assert++;
    if (underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_sticky: got %b, expected 1", underflow);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_assert++;
    if (underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_clear: got %b, expected 0", underflow);
    end
    tick_until(0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_assert++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL underflow: got de=%b hs=%b vs=%b data=%h, expected de=%b hs=%b vs=%b data=%h",
                 a.de, a.hs, a.vs, a.data, e.de, e.hs, e.vs, e.data);
      end
    end
  endtask

  task automatic test_sof_err();
    vout_t e;
    vout_t a;
    tick();
    n_assert++;
    if (sof_err !== 1'b1) begin
      n_fail++;
      $display("FAIL sof_err_set: got %b, expected 1", sof_err);
    end
    tick_until(0);
    n_assert++;
    if (sof_err !== 1'b1) begin
      n_fail++;
      $display("FAIL sof_err_sticky: got %b, expected 1", sof_err);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_assert++;
    if (sof_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sof_err_clear: got %b, expected 0", sof_err);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_assert++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL sof_err: got de=%b hs=%b vs=%b data=%h, expected de=%b hs=%b vs=%b data=%h",
                 a.de, a.hs, a.vs, a.data, e.de, e.hs, e.vs, e.data);
      end
    end
  endtask

  task automatic test_junk_align();
    vout_t e;
    vout_t a;
    tick_until(10);
    push_junk(3);
    push_frame(16'h0300);
    tick_until(0);
    tick();
    n_assert++;
    if ({vout_de, vout_data} !== {1'b1, 16'h0301}) begin
      n_fail++;
      $display("FAIL sof_first_slot: got de=%b data=%h, expected de=1 data=0301", vout_de, vout_data);
    end
    tick_until(60);
    push_frame(16'h0400);
    tick_until(0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_assert++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL junk_align: got de=%b hs=%b vs=%b data=%h, expected de=%b hs=%b vs=%b data=%h",
                 a.de, a.hs, a.vs, a.data, e.de, e.hs, e.vs, e.data);
      end
    end
  endtask

  task automatic test_reset_mid();
    vout_t e;
    vout_t a;
    tick_until(4);
    rst = 1'b1;
    #1;
    n_assert++;
    if ({vout_de, vout_hs, vout_vs, vout_data, underflow, sof_err, pix_ready} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got de=%b hs=%b vs=%b data=%h uf=%b serr=%b rdy=%b, expected all 0",
               vout_de, vout_hs, vout_vs, vout_data, underflow, sof_err, pix_ready);
    end
    step();
    rst = 1'b0;
    mode = 0;
    pos = 0;
    src_q.delete();
    tick();
    tick_until(20);
    push_junk(2);
    push_frame(16'h0500);
    tick_until(0);
    tick();
    n_assert++;
    if ({vout_de, vout_data} !== {1'b1, 16'h0501}) begin
      n_fail++;
      $display("FAIL recover_first: got de=%b data=%h, expected de=1 data=0501", vout_de, vout_data);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_assert++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL reset_recover: got de=%b hs=%b vs=%b data=%h, expected de=%b hs=%b vs=%b data=%h",
                 a.de, a.hs, a.vs, a.data, e.de, e.hs, e.vs, e.data);
      end
    end
  endtask

  task automatic test_stop();
    vout_t e;
    vout_t a;
    tick_until(30);
    enable = 1'b0;
    tick_until(40);
    enable = 1'b1;
    tick_until(60);
    enable = 1'b0;
    tick_until(0);
    for (int i = 0; i < 8; i++) tick();
    n_assert++;
    if (pix_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready: got %b, expected 0", pix_ready);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_assert++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL stop: got de=%b hs=%b vs=%b data=%h, expected de=%b hs=%b vs=%b data=%h",
                 a.de, a.hs, a.vs, a.data, e.de, e.hs, e.vs, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_blank_align();
    test_stream();
    test_underflow();
    test_sof_err();
    test_junk_align();
    test_reset_mid();
    test_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000, expected completion");
    $fatal(1, "timeout");
  end

endmodule
